// File: rtl/t07_mem_arbiter_if.sv
// Bus bundle between the CPU (fetch + data paths), the external memory port and the
// arbiter. The arbiter uses the slave modport; the CPU/memory side uses master.
interface t07_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_ack_o;
   logic [DATA_W-1:0] if_rdata_o;

   logic              d_req_i;
   logic              d_we_i;
   logic [ADDR_W-1:0] d_addr_i;
   logic [DATA_W-1:0] d_wdata_i;
   logic              d_ack_o;
   logic [DATA_W-1:0] d_rdata_o;

   logic              ext_busy_i;
   logic [DATA_W-1:0] ext_rdata_i;
   logic [ADDR_W-1:0] ext_addr_o;
   logic [DATA_W-1:0] ext_wdata_o;
   logic [1:0]        rwi_o;
   logic              freeze_o;
   logic              err_o;

   modport slave (
      input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
             ext_busy_i, ext_rdata_i,
      output if_ack_o, if_rdata_o, d_ack_o, d_rdata_o,
             ext_addr_o, ext_wdata_o, rwi_o, freeze_o, err_o
   );

   modport master (
      output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
             ext_busy_i, ext_rdata_i,
      input  if_ack_o, if_rdata_o, d_ack_o, d_rdata_o,
             ext_addr_o, ext_wdata_o, rwi_o, freeze_o, err_o
   );
endinterface

// File: rtl/t07_mem_arbiter.sv
// Shares the single external memory/MMIO port between instruction fetch and data
// load/store: busy falling-edge completion, timeout abort, one-cycle acks, CPU freeze.
module t07_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   t07_mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] CMD_IDLE   = 2'b00;
   localparam logic [1:0] CMD_FETCH  = 2'b01;
   localparam logic [1:0] CMD_DREAD  = 2'b10;
   localparam logic [1:0] CMD_DWRITE = 2'b11;
   localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

   state_t            state_q;
   state_t            state_d;
   logic [1:0]        cmd_q;
   logic              grant_data_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic [7:0]        cnt_q;
   logic              busy_q;
   logic              abort_q;

   logic              take_data;
   logic              take_fetch;
   logic              done_ok;
   logic              done_abort;
   logic              busy_fall;
   logic              is_read;

   assign busy_fall = busy_q & ~bus.ext_busy_i;
   assign is_read   = (cmd_q != CMD_DWRITE);

   // Next-state logic; data wins over fetch because it belongs to the instruction in flight
   always_comb begin
      state_d    = state_q;
      take_data  = 1'b0;
      take_fetch = 1'b0;
      done_ok    = 1'b0;
      done_abort = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.d_req_i) begin
               take_data = 1'b1;
               state_d   = S_ISSUE;
            end else if (bus.if_req_i) begin
               take_fetch = 1'b1;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (busy_fall) begin
               done_ok = 1'b1;
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               done_abort = 1'b1;
               state_d    = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Grant latch: address, write data and command are frozen for the whole transaction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_q        <= CMD_IDLE;
         grant_data_q <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else if (take_data) begin
         cmd_q        <= bus.d_we_i ? CMD_DWRITE : CMD_DREAD;
         grant_data_q <= 1'b1;
         addr_q       <= bus.d_addr_i;
         wdata_q      <= bus.d_wdata_i;
      end else if (take_fetch) begin
         cmd_q        <= CMD_FETCH;
         grant_data_q <= 1'b0;
         addr_q       <= bus.if_addr_i;
         wdata_q      <= '0;
      end
   end

   // busy history is cleared in ISSUE so a level left over from before the grant never reads as a fall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         if (state_q == S_ISSUE) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
         end else begin
            busy_q <= bus.ext_busy_i;
            if (state_q == S_WAIT) begin
               cnt_q <= cnt_q + 8'd1;
            end
         end
         if (take_data || take_fetch) begin
            abort_q <= 1'b0;
         end else if (done_abort) begin
            abort_q <= 1'b1;
         end
      end
   end

   // Read data is held per requester until that requester's next completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else if ((done_ok || done_abort) && is_read) begin
         if (grant_data_q) begin
            d_rdata_q <= done_ok ? bus.ext_rdata_i : '0;
         end else begin
            if_rdata_q <= done_ok ? bus.ext_rdata_i : '0;
         end
      end
   end

   assign bus.rwi_o       = (state_q == S_ISSUE || state_q == S_WAIT) ? cmd_q : CMD_IDLE;
   assign bus.ext_addr_o  = addr_q;
   assign bus.ext_wdata_o = wdata_q;
   assign bus.if_ack_o    = (state_q == S_DONE) && !grant_data_q;
   assign bus.d_ack_o     = (state_q == S_DONE) && grant_data_q;
   assign bus.err_o       = (state_q == S_DONE) && abort_q;
   assign bus.if_rdata_o  = if_rdata_q;
   assign bus.d_rdata_o   = d_rdata_q;
   assign bus.freeze_o    = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                            ((state_q == S_IDLE) && (bus.if_req_i || bus.d_req_i));

endmodule
